// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg
// Shared definitions for the load/store unit.
// Contents:
//   - lsu_state_e   : FSM state encoding
//   - F3_*          : RV32I load/store funct3 codes
//   - ERR_*         : response error codes
//   - classify_req  : request legality/alignment/range check in priority order
package dmem_lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  // Illegal funct3 outranks misalignment, which outranks out-of-range.
  // Stores have no unsigned variants, so BU/HU are illegal for them.
  function automatic logic [1:0] classify_req(
    input logic       we,
    input logic [2:0] funct3,
    input logic [1:0] addr_lo,
    input logic       in_range
  );
    logic       legal;
    logic       misaligned;
    logic [1:0] err;
    if (we) begin
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end else begin
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
              (funct3 == F3_BU) || (funct3 == F3_HU);
    end
    case (funct3)
      F3_H, F3_HU: misaligned = addr_lo[0];
      F3_W:        misaligned = (addr_lo != 2'b00);
      default:     misaligned = 1'b0;
    endcase
    if (!legal) begin
      err = ERR_ILLEGAL;
    end else if (misaligned) begin
      err = ERR_MISALIGN;
    end else if (!in_range) begin
      err = ERR_RANGE;
    end else begin
      err = ERR_OK;
    end
    return err;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if
// Bundles the core-side request/response handshake and the word-only data
// memory bus of the load/store unit.
// Modports:
//   slave  : the LSU view (takes requests, drives memory strobes)
//   master : the environment view (core issuing requests + memory model)
// Signals:
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata : request
//   resp_valid/resp_rdata/resp_err                           : completion pulse
//   busy                                                     : LSU not idle
//   mem_read/mem_write/mem_addr/mem_wdata/mem_rdata          : memory bus
interface dmem_lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        busy;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy,
           mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/lsu_align.sv
// lsu_align
// Purely combinational lane logic for the load/store unit.
// Ports:
//   mem_word   in  32  word read from data memory
//   wdata      in  16  right-aligned store data (only SB/SH use it)
//   byte_off   in   2  addr[1:0] of the access
//   funct3     in   3  RV32I access size/sign code
//   load_value out 32  selected lane, sign- or zero-extended
//   store_word out 32  mem_word with the addressed lane(s) replaced
module lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [15:0] wdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] load_value,
  output logic [31:0] store_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'h00;
    case (byte_off)
      2'd0: byte_lane = mem_word[7:0];
      2'd1: byte_lane = mem_word[15:8];
      2'd2: byte_lane = mem_word[23:16];
      2'd3: byte_lane = mem_word[31:24];
      default: byte_lane = 8'h00;
    endcase
    half_lane = byte_off[1] ? mem_word[31:16] : mem_word[15:0];

    case (funct3)
      F3_B:    load_value = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    load_value = {{16{half_lane[15]}}, half_lane};
      F3_BU:   load_value = {24'h000000, byte_lane};
      F3_HU:   load_value = {16'h0000, half_lane};
      default: load_value = mem_word;
    endcase
  end

  // Full-word stores never pass through here, so any other funct3 leaves
  // the word untouched.
  always_comb begin
    store_word = mem_word;
    case (funct3)
      F3_B: begin
        case (byte_off)
          2'd0: store_word[7:0]   = wdata[7:0];
          2'd1: store_word[15:8]  = wdata[7:0];
          2'd2: store_word[23:16] = wdata[7:0];
          2'd3: store_word[31:24] = wdata[7:0];
          default: store_word = mem_word;
        endcase
      end
      F3_H: begin
        if (byte_off[1]) begin
          store_word[31:16] = wdata;
        end else begin
          store_word[15:0] = wdata;
        end
      end
      default: store_word = mem_word;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu
// Multi-cycle load/store initiator between the core memory stage and a
// word-only data memory. Sub-word stores are done as read-modify-write,
// sub-word loads are extended, and bad requests are answered with an error
// code without any memory access.
// Ports:
//   clk   in  rising-edge clock
//   rst   in  synchronous active-high reset
//   bus   dmem_lsu_if.slave : request/response handshake and memory bus
// Parameters:
//   MEM_WORDS : number of 32-bit words behind the memory bus
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic       clk,
  input  logic       rst,
  dmem_lsu_if.slave  bus
);

  lsu_state_e  state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] merged_q, merged_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [1:0]  resp_err_q, resp_err_d;

  logic        accept;
  logic        in_range;
  logic [1:0]  req_err;
  logic        mem_active;
  logic [31:0] load_value;
  logic [31:0] store_word;

  lsu_align u_align (
    .mem_word   (bus.mem_rdata),
    .wdata      (wdata_q),
    .byte_off   (addr_q[1:0]),
    .funct3     (funct3_q),
    .load_value (load_value),
    .store_word (store_word)
  );

  assign bus.req_ready = (state_q == ST_IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign in_range      = (bus.req_addr[31:2] < 30'(MEM_WORDS));
  assign req_err       = classify_req(bus.req_we, bus.req_funct3,
                                      bus.req_addr[1:0], in_range);

  // The request kind is carried by the state itself, so only the fields
  // needed later (size, address, low store data) are latched.
  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    merged_d     = merged_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata[15:0];
          if (req_err != ERR_OK) begin
            resp_err_d   = req_err;
            resp_rdata_d = 32'h0;
            state_d      = ST_RESP;
          end else if (!bus.req_we) begin
            state_d = ST_LOAD;
          end else if (bus.req_funct3 == F3_W) begin
            merged_d = bus.req_wdata;
            state_d  = ST_WRITE;
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_LOAD: begin
        resp_rdata_d = load_value;
        state_d      = ST_RESP;
      end
      ST_RMW_RD: begin
        merged_d = store_word;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_rdata_d = 32'h0;
        resp_err_d   = ERR_OK;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      funct3_q     <= 3'b000;
      addr_q       <= 32'h0;
      wdata_q      <= 16'h0;
      merged_q     <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= ERR_OK;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      merged_q     <= merged_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Strobes are masked by rst so a reset landing on the WRITE cycle can
  // never corrupt memory; the bus is driven to zero outside memory states.
  assign mem_active    = (state_q == ST_LOAD) || (state_q == ST_RMW_RD) ||
                         (state_q == ST_WRITE);
  assign bus.mem_read  = !rst && ((state_q == ST_LOAD) || (state_q == ST_RMW_RD));
  assign bus.mem_write = !rst && (state_q == ST_WRITE);
  assign bus.mem_addr  = mem_active ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.mem_wdata = (state_q == ST_WRITE) ? merged_q : 32'h0;

  assign bus.resp_valid = (state_q == ST_RESP) && !rst;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu
// Self-checking bench for dmem_lsu. Requests are issued by applyStimulus,
// which queues the hand-computed response and its due cycle; an independent
// monitor pops the queue on every resp_valid pulse. A behavioural word
// memory sits on the memory bus and a strobe monitor logs reads and writes.
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  localparam int MEM_WORDS = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dmem_lsu_if bus ();

  dmem_lsu #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural data memory with a bench-side preload port.
  logic [31:0] mem [0:MEM_WORDS-1] = '{default: 32'h0};
  logic        tb_wr_en   = 1'b0;
  logic [7:0]  tb_wr_idx  = 8'h0;
  logic [31:0] tb_wr_data = 32'h0;

  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  always @(posedge clk) begin
    if (tb_wr_en) begin
      mem[tb_wr_idx] <= tb_wr_data;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, required);
    end
  endtask

  // Scoreboard queues.
  logic [31:0] exp_rdata_q [$];
  logic [1:0]  exp_err_q   [$];
  int          exp_due_q   [$];
  string       exp_name_q  [$];

  always @(negedge clk) begin
    if (bus.resp_valid) begin
      if (exp_rdata_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected resp_valid at cycle %0d: got 1, required 0", cyc);
      end else begin
        string       nm;
        logic [31:0] er;
        logic [1:0]  ee;
        int          ed;
        nm = exp_name_q.pop_front();
        er = exp_rdata_q.pop_front();
        ee = exp_err_q.pop_front();
        ed = exp_due_q.pop_front();
        checkOutput({nm, " rdata"}, bus.resp_rdata, er);
        checkOutput({nm, " err"}, 32'(bus.resp_err), 32'(ee));
        checkOutput({nm, " resp cycle"}, cyc, ed);
      end
    end
  end

  // Memory strobe log.
  int          read_count = 0;
  int          write_count = 0;
  int          last_read_cyc = -1;
  int          last_write_cyc = -1;
  logic [31:0] last_write_addr = 32'h0;
  logic [31:0] last_write_data = 32'h0;

  always @(negedge clk) begin
    if (bus.mem_read) begin
      read_count++;
      last_read_cyc = cyc;
    end
    if (bus.mem_write) begin
      write_count++;
      last_write_cyc  = cyc;
      last_write_addr = bus.mem_addr;
      last_write_data = bus.mem_wdata;
    end
  end

  task automatic applyStimulus(
    input  string       name,
    input  logic        we,
    input  logic [2:0]  f3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  bit          expect_resp,
    input  logic [31:0] exp_rdata,
    input  logic [1:0]  exp_err,
    input  int          exp_lat,
    input  bit          hold,
    output int          acc_cyc
  );
    int waited;
    waited = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    while (!bus.req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s accept: req_ready got 0, required 1 within 50 cycles", name);
    end
    acc_cyc = cyc;
    if (expect_resp) begin
      exp_name_q.push_back(name);
      exp_rdata_q.push_back(exp_rdata);
      exp_err_q.push_back(exp_err);
      exp_due_q.push_back(acc_cyc + exp_lat);
    end
    @(posedge clk);
    #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (exp_rdata_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_rdata_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s drain: %0d responses outstanding, required 0", name,
               exp_rdata_q.size());
    end
    @(negedge clk);
  endtask

  int acc, acc2, rc0, wc0;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;

    // Preload word 0x10 while reset is held.
    tb_wr_en   = 1'b1;
    tb_wr_idx  = 8'd4;
    tb_wr_data = 32'h8899AABB;
    @(posedge clk);
    #1 tb_wr_en = 1'b0;
    @(negedge clk);
    checkOutput("reset resp_valid", 32'(bus.resp_valid), 32'h0);
    checkOutput("reset resp_rdata", bus.resp_rdata, 32'h0);
    checkOutput("reset resp_err", 32'(bus.resp_err), 32'h0);
    checkOutput("reset req_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("reset mem_write", 32'(bus.mem_write), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle req_ready", 32'(bus.req_ready), 32'h1);
    checkOutput("idle busy", 32'(bus.busy), 32'h0);

    // Sub-word loads from 0x8899AABB.
    applyStimulus("LB 0x11",  1'b0, F3_B,  32'h11, 32'h0, 1'b1, 32'hFFFFFFAA, ERR_OK, 2, 1'b0, acc);
    applyStimulus("LBU 0x13", 1'b0, F3_BU, 32'h13, 32'h0, 1'b1, 32'h00000088, ERR_OK, 2, 1'b0, acc);
    applyStimulus("LHU 0x12", 1'b0, F3_HU, 32'h12, 32'h0, 1'b1, 32'h00008899, ERR_OK, 2, 1'b0, acc);
    applyStimulus("LH 0x12",  1'b0, F3_H,  32'h12, 32'h0, 1'b1, 32'hFFFF8899, ERR_OK, 2, 1'b0, acc);
    applyStimulus("LB 0x10",  1'b0, F3_B,  32'h10, 32'h0, 1'b1, 32'hFFFFFFBB, ERR_OK, 2, 1'b0, acc);
    waitDrain("loads");

    // Halfword read-modify-write.
    applyStimulus("SH 0x12", 1'b1, F3_H, 32'h12, 32'h00001234, 1'b1, 32'h0, ERR_OK, 3, 1'b0, acc);
    waitDrain("SH");
    checkOutput("SH read cycle", last_read_cyc, acc + 1);
    checkOutput("SH write cycle", last_write_cyc, acc + 2);
    checkOutput("SH mem_addr", last_write_addr, 32'h10);
    checkOutput("SH mem_wdata", last_write_data, 32'h1234AABB);
    applyStimulus("LW 0x10", 1'b0, F3_W, 32'h10, 32'h0, 1'b1, 32'h1234AABB, ERR_OK, 2, 1'b0, acc);
    applyStimulus("SB 0x13", 1'b1, F3_B, 32'h13, 32'hFFFFFF55, 1'b1, 32'h0, ERR_OK, 3, 1'b0, acc);
    waitDrain("SB");
    checkOutput("SB mem_wdata", last_write_data, 32'h5534AABB);
    checkOutput("SB memory word", mem[4], 32'h5534AABB);

    // Full-word store: no read phase.
    rc0 = read_count;
    wc0 = write_count;
    applyStimulus("SW 0x20", 1'b1, F3_W, 32'h20, 32'hDEADBEEF, 1'b1, 32'h0, ERR_OK, 2, 1'b0, acc);
    waitDrain("SW");
    checkOutput("SW read strobes", read_count - rc0, 0);
    checkOutput("SW write strobes", write_count - wc0, 1);
    checkOutput("SW write cycle", last_write_cyc, acc + 1);
    checkOutput("SW mem_wdata", last_write_data, 32'hDEADBEEF);
    checkOutput("SW memory word", mem[8], 32'hDEADBEEF);

    // Last in-range word, then rejected requests with no memory traffic.
    applyStimulus("LW 0x3FC", 1'b0, F3_W, 32'h3FC, 32'h0, 1'b1, 32'h0, ERR_OK, 2, 1'b0, acc);
    waitDrain("LW last word");
    rc0 = read_count;
    wc0 = write_count;
    applyStimulus("LW 0x0E misalign", 1'b0, F3_W,   32'h0E,  32'h0, 1'b1, 32'h0, ERR_MISALIGN, 1, 1'b0, acc);
    applyStimulus("LW 0x400 range",   1'b0, F3_W,   32'h400, 32'h0, 1'b1, 32'h0, ERR_RANGE,    1, 1'b0, acc);
    applyStimulus("load f3 011",      1'b0, 3'b011, 32'h10,  32'h0, 1'b1, 32'h0, ERR_ILLEGAL,  1, 1'b0, acc);
    applyStimulus("store f3 100",     1'b1, F3_BU,  32'h10,  32'h1, 1'b1, 32'h0, ERR_ILLEGAL,  1, 1'b0, acc);
    applyStimulus("SW 0x400 range",   1'b1, F3_W,   32'h400, 32'h1, 1'b1, 32'h0, ERR_RANGE,    1, 1'b0, acc);
    applyStimulus("LH 0x401 prio",    1'b0, F3_H,   32'h401, 32'h0, 1'b1, 32'h0, ERR_MISALIGN, 1, 1'b0, acc);
    applyStimulus("f3 011 0x401 prio",1'b0, 3'b011, 32'h401, 32'h0, 1'b1, 32'h0, ERR_ILLEGAL,  1, 1'b0, acc);
    waitDrain("errors");
    checkOutput("error read strobes", read_count - rc0, 0);
    checkOutput("error write strobes", write_count - wc0, 0);

    // Reset landing on the WRITE cycle of an SB.
    rc0 = read_count;
    wc0 = write_count;
    applyStimulus("SB reset", 1'b1, F3_B, 32'h10, 32'h00000077, 1'b0, 32'h0, ERR_OK, 3, 1'b0, acc);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("reset-in-WRITE mem_write", 32'(bus.mem_write), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post-reset req_ready", 32'(bus.req_ready), 32'h1);
    checkOutput("post-reset write strobes", write_count - wc0, 0);
    checkOutput("post-reset read strobes", read_count - rc0, 1);
    repeat (3) @(negedge clk);
    checkOutput("post-reset memory word", mem[4], 32'h5534AABB);

    // Back-to-back with req_valid held high.
    applyStimulus("b2b LW 0x20", 1'b0, F3_W, 32'h20, 32'h0, 1'b1, 32'hDEADBEEF, ERR_OK, 2, 1'b1, acc);
    applyStimulus("b2b SW 0x24", 1'b1, F3_W, 32'h24, 32'h0BADF00D, 1'b1, 32'h0, ERR_OK, 2, 1'b0, acc2);
    waitDrain("back-to-back");
    checkOutput("b2b accept gap", acc2 - acc, 3);
    checkOutput("b2b memory word", mem[9], 32'h0BADF00D);

    repeat (3) @(negedge clk);
    checkOutput("outstanding responses", exp_rdata_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Multi-cycle load/store initiator that sits between the core's memory stage and the word-only data memory.
- Accepts one request per handshake and issues word-aligned read/write strobes to the data memory.
- Implements sub-word stores (SB/SH) as read-modify-write, because the data memory writes only whole words.
- Sign- or zero-extends sub-word loads, and rejects misaligned, out-of-range or illegal accesses without touching memory.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in the data memory; word index addr[31:2] >= MEM_WORDS is out of range.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3.
- busy  out  1  state != IDLE.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  combinational read data from memory.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port rst.
- Reset values: state=IDLE; resp_valid=0, resp_rdata=0, resp_err=00.
- mem_read, mem_write, mem_addr and mem_wdata are 0 whenever state is not LOAD, RMW_RD or WRITE.
- mem_read and mem_write are gated by !rst, so reset in the middle of an operation never produces a memory write in the reset cycle.
- req_ready = (state==IDLE) && !rst.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE: on req_valid && req_ready, latch we, funct3, addr and wdata, then check in priority order:
  - illegal funct3 → err 11. Legal loads: 000, 001, 010, 100, 101. Legal stores: 000, 001, 010.
  - misaligned → err 01 (halfword with addr[0]!=0, or word with addr[1:0]!=0).
  - out of range → err 10.
  - Any error: go to RESP with the err code latched; no memory access is made.
- Next state for a legal request: load → LOAD; SW → WRITE (merged word = wdata); SB/SH → RMW_RD.
- LOAD: mem_read=1. Select the byte/half lane by addr[1:0] from mem_rdata, extend it (LB/LH sign-extend, LBU/LHU zero-extend), register it into resp_rdata, then go to RESP.
- RMW_RD: mem_read=1. Register merged word = mem_rdata with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0], then go to WRITE.
- WRITE: mem_write=1, mem_wdata=merged word, for exactly one cycle, then go to RESP.
- RESP: resp_valid=1 for exactly one cycle with registered resp_rdata and resp_err, then go to IDLE.
  - There is no response backpressure; the core must sample the pulse.
  - resp_rdata and resp_err are cleared to 0 when leaving RESP.
- Latency, counting the accept cycle as 0: resp_valid at cycle 2 for loads and SW, cycle 3 for SB/SH, cycle 1 for errors.
- Throughput: the next request can be accepted in the cycle after RESP.
- req_valid while busy is ignored (req_ready=0); the request fields must be held stable by the core.
- Lane map: byte k = bits [8k+7:8k]; halfword at addr[1]=1 = bits [31:16].
- Reset asserted in any state: next state IDLE, and the in-flight request is discarded with no response.

Decomposition:
- Shared package dmem_lsu_pkg holds:
  - the state enum;
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - error codes ERR_OK, ERR_MISALIGN, ERR_RANGE, ERR_ILLEGAL.
- One combinational sub-module, lsu_align, provides:
  - load lane extract and extend: (rdata, addr[1:0], funct3) → value;
  - store merge: (old word, wdata, addr[1:0], funct3) → word.

Test Plan:
- Memory word 0x10 = 0x8899AABB; LB at 0x11 → resp_valid at cycle 2, resp_rdata=0xFFFFFFAA, err 00. LBU at 0x13 → 0x00000088. LHU at 0x12 → 0x00008899.
- SH at 0x12, wdata=0x00001234 → mem_read at cycle 1, mem_write at cycle 2 with mem_addr=0x10 and mem_wdata=0x1234AABB, resp_valid at cycle 3. A following LW at 0x10 → 0x1234AABB.
- SW at 0x20, wdata=0xDEADBEEF → single mem_write at cycle 1 with mem_wdata=0xDEADBEEF, mem_read never asserted, resp_valid at cycle 2.
- LW at 0x0E → resp_err=01 at cycle 1. LW at 0x400 with MEM_WORDS=256 → err=10. Load with funct3=011 → err=11. No mem_read/mem_write strobe in any of these.
- Issue SB at 0x10, assert rst during the WRITE cycle → mem_write stays 0 in that cycle, no resp_valid, memory word unchanged, req_ready=1 the cycle after rst deasserts.
- Back-to-back: hold req_valid with an LW then an SW → second request accepted only in the cycle after the first RESP; exactly one resp_valid pulse per request.
